alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: a sequential 5-bit-opcode ALU with a Z80-style flag register.
// Shift and rotate operations take one cycle per bit position. All other
// operations complete in a single cycle.
//
// Ports
//   clk        : the single clock; all state changes on its rising edge
//   reset      : synchronous, active-high
//   in_valid   : an operation is offered on opcode/a/b
//   in_ready   : the block accepts an operation this cycle (IDLE, not in reset)
//   opcode     : operation select (5 bits)
//   a, b       : operands (WIDTH bits each)
//   out        : registered result
//   out_valid  : out/flags hold a completed result (DONE state)
//   out_ready  : the consumer takes the result
//   flags      : registered flags {S,Z,H,V,N,C}
//
// Optional feature: define ALU_DAA_EN (and use WIDTH==8) to make opcode 15 a
// Z80 decimal adjust. Otherwise opcode 15 is illegal.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       flags
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_SBC = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_CP  = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL = 5'd9,  OP_SRA = 5'd10, OP_ROL = 5'd11;
  localparam logic [4:0] OP_ROR = 5'd12, OP_INC = 5'd13, OP_DEC = 5'd14, OP_DAA = 5'd15;

  localparam logic [WIDTH-1:0] WIDTH_L = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  // Even parity: 1 when the number of set bits is even.
  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [5:0]        flags_q, flags_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [4:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cin_s, shift_op_s, legal_s;
  logic              h_s, v_s, nf_s, c_s;
  logic [CNT_W-1:0]  n_s;
  logic [WIDTH:0]    add_s, sub_s;
  logic [4:0]        add_lo_s, sub_lo_s;
  logic [WIDTH-1:0]  inc_s, dec_s, res_s, step_s;
  logic [5:0]        flg_s;
  logic              add_v_s, sub_v_s, bitout_s;

  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign out_valid  = (state_q == S_DONE);
  assign out        = out_q;
  assign flags      = flags_q;

  // Only ADC/SBC consume the registered carry.
  assign cin_s      = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? flags_q[0] : 1'b0;
  assign shift_op_s = (opcode >= OP_SLL) && (opcode <= OP_ROR);
  assign n_s        = CNT_W'(b % WIDTH_L);

  // Carry/borrow out of the top bit is the extra MSB; nibble sums give H.
  assign add_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
  assign sub_s    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};
  assign add_lo_s = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin_s};
  assign sub_lo_s = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0000, cin_s};
  assign inc_s    = a + WIDTH'(1);
  assign dec_s    = a - WIDTH'(1);
  assign add_v_s  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_v_s  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_DAA_EN
  logic [7:0] daa_a_s, daa_corr_s, daa_res_s;
  logic       daa_c_s, daa_h_s;

  // Z80 decimal adjust of a, driven by the registered N, H and C flags.
  always_comb begin
    daa_a_s = 8'(a);
    if (flags_q[3] || (daa_a_s[3:0] > 4'd9)) daa_corr_s[3:0] = 4'h6;
    else                                     daa_corr_s[3:0] = 4'h0;
    if (flags_q[0] || (daa_a_s > 8'h99)) begin
      daa_corr_s[7:4] = 4'h6;
      daa_c_s         = 1'b1;
    end else begin
      daa_corr_s[7:4] = 4'h0;
      daa_c_s         = 1'b0;
    end
    if (flags_q[1]) begin
      daa_res_s = daa_a_s - daa_corr_s;
      daa_h_s   = flags_q[3] && (daa_a_s[3:0] < 4'd6);
    end else begin
      daa_res_s = daa_a_s + daa_corr_s;
      daa_h_s   = (daa_a_s[3:0] > 4'd9);
    end
  end
`endif

  // Single-cycle result and flags for the operation offered at accept.
  // Shift ops here cover only the n==0 case (result is a, C kept).
  always_comb begin
    res_s   = '0;
    h_s     = 1'b0;
    v_s     = 1'b0;
    nf_s    = 1'b0;
    c_s     = flags_q[0];
    legal_s = 1'b1;
    case (opcode)
      OP_ADD, OP_ADC: begin
        res_s = add_s[WIDTH-1:0]; h_s = add_lo_s[4]; v_s = add_v_s; c_s = add_s[WIDTH];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        res_s = (opcode == OP_CP) ? a : sub_s[WIDTH-1:0];
        h_s = sub_lo_s[4]; v_s = sub_v_s; nf_s = 1'b1; c_s = sub_s[WIDTH];
      end
      OP_AND: begin
        res_s = a & b; h_s = 1'b1; v_s = even_par(res_s); c_s = 1'b0;
      end
      OP_OR: begin
        res_s = a | b; v_s = even_par(res_s); c_s = 1'b0;
      end
      OP_XOR: begin
        res_s = a ^ b; v_s = even_par(res_s); c_s = 1'b0;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
        res_s = a; v_s = even_par(res_s);
      end
      OP_INC: begin
        res_s = inc_s; h_s = (a[3:0] == 4'hF); v_s = (a == SMAX);
      end
      OP_DEC: begin
        res_s = dec_s; h_s = (a[3:0] == 4'h0); v_s = (a == SMIN); nf_s = 1'b1;
      end
      OP_DAA: begin
`ifdef ALU_DAA_EN
        if (WIDTH == 8) begin
          res_s = WIDTH'(daa_res_s); h_s = daa_h_s; c_s = daa_c_s;
          v_s = even_par(res_s);
        end else begin
          legal_s = 1'b0;
        end
`else
        legal_s = 1'b0;
`endif
      end
      default: legal_s = 1'b0;
    endcase
    if (legal_s) flg_s = {res_s[WIDTH-1], (res_s == '0), h_s, v_s, nf_s, c_s};
    else         flg_s = flags_q;
  end

  // One-bit shift/rotate step of the working register for the captured op.
  always_comb begin
    step_s   = sh_q;
    bitout_s = 1'b0;
    case (op_q)
      OP_SLL: begin step_s = {sh_q[WIDTH-2:0], 1'b0};         bitout_s = sh_q[WIDTH-1]; end
      OP_SRL: begin step_s = {1'b0, sh_q[WIDTH-1:1]};         bitout_s = sh_q[0];       end
      OP_SRA: begin step_s = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; bitout_s = sh_q[0];      end
      OP_ROL: begin step_s = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; bitout_s = sh_q[WIDTH-1]; end
      OP_ROR: begin step_s = {sh_q[0], sh_q[WIDTH-1:1]};      bitout_s = sh_q[0];       end
      default: begin step_s = sh_q;                           bitout_s = 1'b0;          end
    endcase
  end

  // Next-state logic: accept in IDLE, count down in SHIFT, hold in DONE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    sh_d    = sh_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (shift_op_s && (n_s != '0)) begin
            state_d = S_SHIFT;
            sh_d    = a;
            op_d    = opcode;
            cnt_d   = n_s;
          end else begin
            state_d = S_DONE;
            out_d   = res_s;
            flags_d = flg_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sh_d  = step_s;
        cnt_d = cnt_q - CNT_W'(1);
        // The last step writes the result directly so DONE follows n shifts.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          out_d   = step_s;
          flags_d = {step_s[WIDTH-1], (step_s == '0), 1'b0, even_par(step_s), 1'b0, bitout_s};
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      flags_q <= 6'b000000;
      sh_q    <= '0;
      op_q    <= 5'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic [4:0] opcode;
  logic [7:0] a, b, out;
  logic [5:0] flags;

  int         n_chk = 0;
  int         n_err = 0;
  logic [5:0] m_flags = 6'b000000;
  int         o_out, o_flg, f_prev;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input int op, input int av, input int bv, input logic [5:0] fin,
                                output int r, output logic [5:0] fo, output int lat);
    int ci, sa, sb, s, ss, k, x, lastb, lo, corr;
    logic h, v, n, c, legal;
    logic [7:0] rv;
    ci = ((op == 1) || (op == 3)) ? int'(fin[0]) : 0;
    sa = (av > 127) ? av - 256 : av;
    sb = (bv > 127) ? bv - 256 : bv;
    r = 0; h = 0; v = 0; n = 0; c = fin[0]; legal = 1; lat = 1;
    case (op)
      0, 1: begin
        s = av + bv + ci; r = s & 255; c = (s > 255);
        h = (((av & 15) + (bv & 15) + ci) > 15);
        ss = sa + sb + ci; v = (ss > 127) || (ss < -128);
      end
      2, 3, 7: begin
        s = av - bv - ci; r = (op == 7) ? av : (s & 255); c = (s < 0);
        h = (((av & 15) - (bv & 15) - ci) < 0);
        ss = sa - sb - ci; v = (ss > 127) || (ss < -128); n = 1;
      end
      4: begin r = av & bv; h = 1; c = 0; rv = r[7:0]; v = ~^rv; end
      5: begin r = av | bv; c = 0; rv = r[7:0]; v = ~^rv; end
      6: begin r = av ^ bv; c = 0; rv = r[7:0]; v = ~^rv; end
      8, 9, 10, 11, 12: begin
        k = bv % 8; x = av; lastb = 0;
        for (int i = 0; i < k; i++) begin
          case (op)
            8:  begin lastb = (x >> 7) & 1; x = (x << 1) & 255; end
            9:  begin lastb = x & 1; x = x >> 1; end
            10: begin lastb = x & 1; x = (x >> 1) | (x & 128); end
            11: begin lastb = (x >> 7) & 1; x = ((x << 1) | (x >> 7)) & 255; end
            default: begin lastb = x & 1; x = (x >> 1) | ((x & 1) << 7); end
          endcase
        end
        r = x; rv = r[7:0]; v = ~^rv;
        if (k != 0) begin c = lastb[0]; lat = k + 1; end
      end
      13: begin r = (av + 1) & 255; h = (((av & 15) + 1) > 15); v = ((sa + 1) > 127); end
      14: begin r = (av - 1) & 255; h = (((av & 15) - 1) < 0); v = ((sa - 1) < -128); n = 1; end
`ifdef ALU_DAA_EN
      15: begin
        lo = av & 15; corr = 0; c = 0;
        if (fin[3] || (lo > 9)) corr = 6;
        if (fin[0] || (av > 'h99)) begin corr = corr + 96; c = 1; end
        r = fin[1] ? ((av - corr) & 255) : ((av + corr) & 255);
        h = fin[1] ? (fin[3] && (lo < 6)) : (lo > 9);
        rv = r[7:0]; v = ~^rv;
      end
`endif
      default: legal = 0;
    endcase
    if (legal) fo = {(r > 127), (r == 0), h, v, n, c};
    else begin fo = fin; r = 0; end
  endfunction

  // Issue one operation, check latency, busy behaviour, result and hold.
  task automatic do_op(input int op, input int av, input int bv, input int hold,
                       output int o_r, output int o_f);
    int er, el, cyc;
    logic [5:0] ef;
    model(op, av, bv, m_flags, er, ef, el);
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; opcode = op[4:0]; a = av[7:0]; b = bv[7:0]; out_ready = 1'b0;
    @(negedge clk);
    cyc = 1;
    in_valid = 1'(($urandom % 2)); opcode = 5'($urandom); a = 8'($urandom); b = 8'($urandom);
    while (!out_valid && cyc < 64) begin
      chk("ready_busy", in_ready, 0);
      @(negedge clk);
      cyc++;
      opcode = 5'($urandom); a = 8'($urandom); b = 8'($urandom);
    end
    chk($sformatf("op%0d_latency", op), cyc, el);
    chk($sformatf("op%0d_out", op), out, er);
    chk($sformatf("op%0d_flags", op), flags, ef);
    o_r = out; o_f = flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_out", out, er);
      chk("hold_flags", flags, ef);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("back_ready", in_ready, 1);
    chk("back_valid", out_valid, 0);
    m_flags = ef;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 5'd0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1);

    do_op(0, 'h7F, 'h01, 0, o_out, o_flg);
    chk("add7f_out", o_out, 'h80);
    chk("add7f_flags", o_flg, 6'b101100);

    do_op(2, 'h00, 'h01, 0, o_out, o_flg);
    do_op(3, 'h00, 'h00, 1, o_out, o_flg);
    chk("sbc_out", o_out, 'hFF);
    chk("sbc_flags", o_flg, 6'b101011);

    do_op(0, 'h00, 'h00, 0, o_out, o_flg);
    do_op(11, 'h81, 8, 0, o_out, o_flg);
    chk("rol8_out", o_out, 'h81);
    chk("rol8_c", o_flg & 1, 0);
    do_op(11, 'h81, 9, 0, o_out, o_flg);
    chk("rol9_out", o_out, 'h03);
    chk("rol9_c", o_flg & 1, 1);

    do_op(9, 'hF0, 4, 5, o_out, o_flg);
    chk("srl_out", o_out, 'h0F);

    do_op(0, 'h15, 'h27, 0, o_out, o_flg);
    chk("add15_out", o_out, 'h3C);
    f_prev = o_flg;
    do_op(15, 'h3C, 'h00, 0, o_out, o_flg);
`ifdef ALU_DAA_EN
    chk("daa_out", o_out, 'h42);
    chk("daa_c", o_flg & 1, 0);
`else
    chk("daa_illegal_out", o_out, 0);
    chk("daa_illegal_flags", o_flg, f_prev);
`endif

    do_op(13, 'h7F, 0, 0, o_out, o_flg);
    do_op(14, 'h80, 0, 0, o_out, o_flg);
    do_op(13, 'hFF, 0, 1, o_out, o_flg);
    do_op(20, 'h12, 'h34, 0, o_out, o_flg);

    // Reset on the third SHIFT cycle of SRA by 7.
    do_op(0, 'h7F, 'h01, 0, o_out, o_flg);
    @(negedge clk);
    in_valid = 1'b1; opcode = 5'd10; a = 8'h80; b = 8'd7; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_ready_low", in_ready, 0);
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", in_ready, 1);
    chk("midrst_flags_after", flags, 0);
    m_flags = 6'b000000;

    for (int t = 0; t < 300; t++) begin
      do_op($urandom_range(0, 19), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 2), o_out, o_flg);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
